// File: rtl/game_pkg.sv
// Shared definitions for the game round controller: FSM encodings and parameter defaults.
package game_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_REQ    = 3'd1,
        S_WAIT_Q = 3'd2,
        S_PLAY   = 3'd3,
        S_RESULT = 3'd4,
        S_OVER   = 3'd5
    } state_e;

    localparam int DEF_MAX_LIVES  = 3;
    localparam int DEF_ROUND_TIME = 10;

endpackage

// File: rtl/round_timer.sv
// Per-round countdown in seconds: loads ROUND_TIME, counts down on dec, flags expiry.
module round_timer
    import game_pkg::*;
#(
    parameter int ROUND_TIME = DEF_ROUND_TIME
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       dec,
    output logic [3:0] time_left,
    output logic       expire
);

    // Expiry is the tick that would take the count from 1 to 0.
    assign expire = dec && (time_left == 4'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            time_left <= 4'd0;
        else if (load)
            time_left <= 4'(ROUND_TIME);
        else if (dec && time_left != 4'd0)
            time_left <= time_left - 4'd1;
    end

endmodule

// File: rtl/game_round_ctrl.sv
// Game round sequencer: question request, key judging with release interlock, lives and score.
// Optional STREAK_BONUS_EN adds a 2-bit win streak giving +2 per win once the streak reaches 2.
module game_round_ctrl
    import game_pkg::*;
#(
    parameter int MAX_LIVES  = DEF_MAX_LIVES,
    parameter int ROUND_TIME = DEF_ROUND_TIME,
    parameter int SCORE_W    = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               win,
    input  logic               lose,
    input  logic               sec_tick,
    input  logic               q_valid,
    output logic               new_q,
    output logic               round_win,
    output logic               round_lose,
    output logic [SCORE_W-1:0] score,
    output logic [1:0]         lives,
    output logic [3:0]         time_left,
    output logic [2:0]         state,
    output logic               game_over
);

    state_e             st;
    logic               armed;
    logic               key_hit;
    logic               t_load;
    logic               t_dec;
    logic               t_expire;
    logic [1:0]         inc;
    logic [SCORE_W:0]   score_sum;
    logic [SCORE_W-1:0] score_sat;

`ifdef STREAK_BONUS_EN
    logic [1:0] streak;
    assign inc = (streak >= 2'd2) ? 2'd2 : 2'd1;
`else
    assign inc = 2'd1;
`endif

    assign score_sum = {1'b0, score} + {{(SCORE_W-1){1'b0}}, inc};
    assign score_sat = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];

    // A held key only counts once the player has released everything in this round.
    assign key_hit = armed && (win || lose);
    assign t_load  = (st == S_WAIT_Q) && q_valid;
    assign t_dec   = (st == S_PLAY) && sec_tick && !key_hit;

    round_timer #(.ROUND_TIME(ROUND_TIME)) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (t_load),
        .dec       (t_dec),
        .time_left (time_left),
        .expire    (t_expire)
    );

    assign state     = st;
    assign new_q     = (st == S_REQ);
    assign game_over = (st == S_OVER);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st         <= S_IDLE;
            armed      <= 1'b0;
            score      <= '0;
            lives      <= 2'd0;
            round_win  <= 1'b0;
            round_lose <= 1'b0;
`ifdef STREAK_BONUS_EN
            streak     <= 2'd0;
`endif
        end else begin
            round_win  <= 1'b0;
            round_lose <= 1'b0;
            case (st)
                S_IDLE: begin
                    if (start) begin
                        st    <= S_REQ;
                        score <= '0;
                        lives <= 2'(MAX_LIVES);
`ifdef STREAK_BONUS_EN
                        streak <= 2'd0;
`endif
                    end
                end
                S_REQ: st <= S_WAIT_Q;
                S_WAIT_Q: begin
                    if (q_valid) begin
                        st    <= S_PLAY;
                        armed <= 1'b0;
                    end
                end
                S_PLAY: begin
                    // Both keys together judge as a lose; a key result beats a same-cycle tick.
                    if ((armed && lose) || (!key_hit && t_expire)) begin
                        st         <= S_RESULT;
                        round_lose <= 1'b1;
                        if (lives != 2'd0)
                            lives <= lives - 2'd1;
`ifdef STREAK_BONUS_EN
                        streak <= 2'd0;
`endif
                    end else if (armed && win) begin
                        st        <= S_RESULT;
                        round_win <= 1'b1;
                        score     <= score_sat;
`ifdef STREAK_BONUS_EN
                        if (streak != 2'd3)
                            streak <= streak + 2'd1;
`endif
                    end else if (!win && !lose) begin
                        armed <= 1'b1;
                    end
                end
                S_RESULT: st <= (lives == 2'd0) ? S_OVER : S_REQ;
                S_OVER: begin
                    if (start)
                        st <= S_IDLE;
                end
                default: st <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_game_round_ctrl.sv
// Scoreboard bench for game_round_ctrl: expected round results are queued when keys/ticks are driven.
module tb_game_round_ctrl;
    import game_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0, win = 1'b0, lose = 1'b0, sec_tick = 1'b0, q_valid = 1'b0;
    logic       new_q, round_win, round_lose, game_over;
    logic [7:0] score;
    logic [1:0] lives;
    logic [3:0] time_left;
    logic [2:0] state;

    game_round_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .win(win), .lose(lose),
        .sec_tick(sec_tick), .q_valid(q_valid), .new_q(new_q),
        .round_win(round_win), .round_lose(round_lose), .score(score),
        .lives(lives), .time_left(time_left), .state(state), .game_over(game_over)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       w;
        logic [7:0] score;
        logic [1:0] lives;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    int         n_pass = 0;
    int         n_total = 0;
    int         m_score;
    int         m_lives;
    int         m_streak;

    // Result monitor: every round_win/round_lose pulse must match the head of the queue.
    always @(negedge clk) begin
        if (rst_n && (round_win || round_lose)) begin
            n_total++;
            if (exp_q.size() == 0) begin
                $display("FAIL result_unexpected: got win=%b lose=%b score=%0d, required no result", round_win, round_lose, score);
            end else begin
                mon_e = exp_q.pop_front();
                if ({round_win, round_lose, score, lives} !== {mon_e.w, ~mon_e.w, mon_e.score, mon_e.lives})
                    $display("FAIL result: got win=%b lose=%b score=%0d lives=%0d, required win=%b lose=%b score=%0d lives=%0d",
                             round_win, round_lose, score, lives, mon_e.w, ~mon_e.w, mon_e.score, mon_e.lives);
                else
                    n_pass++;
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_state(input logic [2:0] s, input string tag);
        int n = 0;
        while (state !== s && n < 50) begin
            tick();
            n++;
        end
        if (state !== s) begin
            n_total++;
            $display("FAIL %s_timeout: state=%0d, required %0d", tag, state, s);
        end
    endtask

    task automatic model_push(input bit w);
        exp_t e;
        if (w) begin
            int inc = 1;
`ifdef STREAK_BONUS_EN
            if (m_streak >= 2) inc = 2;
            if (m_streak < 3) m_streak++;
`endif
            m_score = (m_score + inc > 255) ? 255 : m_score + inc;
        end else begin
            m_lives--;
            m_streak = 0;
        end
        e.w = w;
        e.score = 8'(m_score);
        e.lives = 2'(m_lives);
        exp_q.push_back(e);
    endtask

    task automatic new_game();
        start = 1'b1;
        tick();
        start = 1'b0;
        m_score = 0;
        m_lives = 3;
        m_streak = 0;
    endtask

    // kind: 0 = win, 1 = lose, 2 = win and lose together
    task automatic play_round(input int kind);
        wait_state(S_WAIT_Q, "play_wait_q");
        q_valid = 1'b1;
        tick();
        q_valid = 1'b0;
        win = 1'b0;
        lose = 1'b0;
        tick();
        win = (kind != 1);
        lose = (kind != 0);
        model_push(kind == 0);
        tick();
        win = 1'b0;
        lose = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        n_total++;
        if (state !== S_IDLE) $display("FAIL reset_state: got %0d, required 0", state); else n_pass++;
        n_total++;
        if ({score, lives, time_left} !== 14'd0) $display("FAIL reset_values: got score=%0d lives=%0d time_left=%0d, required 0", score, lives, time_left); else n_pass++;
        n_total++;
        if ({new_q, round_win, round_lose, game_over} !== 4'b0) $display("FAIL reset_flags: got %b, required 0000", {new_q, round_win, round_lose, game_over}); else n_pass++;
        start = 1'b1;
        tick();
        tick();
        n_total++;
        if (state !== S_IDLE) $display("FAIL reset_hold: got state %0d, required 0", state); else n_pass++;
        start = 1'b0;
        #2 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic_win();
        new_game();
        n_total++;
        if ({state, new_q, lives, score} !== {S_REQ, 1'b1, 2'd3, 8'd0}) $display("FAIL start_req: got state=%0d new_q=%b lives=%0d score=%0d, required 1 1 3 0", state, new_q, lives, score); else n_pass++;
        tick();
        n_total++;
        if ({state, new_q} !== {S_WAIT_Q, 1'b0}) $display("FAIL req_to_wait: got state=%0d new_q=%b, required 2 0", state, new_q); else n_pass++;
        q_valid = 1'b1;
        tick();
        q_valid = 1'b0;
        n_total++;
        if ({state, time_left} !== {S_PLAY, 4'd10}) $display("FAIL play_load: got state=%0d time_left=%0d, required 3 10", state, time_left); else n_pass++;
        tick();
        win = 1'b1;
        model_push(1'b1);
        tick();
        n_total++;
        if ({round_win, score} !== {1'b1, 8'd1}) $display("FAIL first_win: got round_win=%b score=%0d, required 1 1", round_win, score); else n_pass++;
        tick();
        n_total++;
        if ({new_q, round_win} !== 2'b10) $display("FAIL new_q_after_win: got new_q=%b round_win=%b, required 1 0", new_q, round_win); else n_pass++;
        tick();
        win = 1'b0;
    endtask

    task automatic test_interlock();
        wait_state(S_WAIT_Q, "interlock_wait_q");
        win = 1'b1;
        q_valid = 1'b1;
        tick();
        q_valid = 1'b0;
        repeat (5) tick();
        n_total++;
        if (state !== S_PLAY) $display("FAIL interlock_hold: got state=%0d, required 3", state); else n_pass++;
        win = 1'b0;
        tick();
        win = 1'b1;
        model_push(1'b1);
        tick();
        win = 1'b0;
        n_total++;
        if (state !== S_RESULT) $display("FAIL interlock_press: got state=%0d, required 4", state); else n_pass++;
    endtask

    task automatic test_timeout();
        for (int r = 0; r < 3; r++) begin
            wait_state(S_WAIT_Q, "timeout_wait_q");
            if (r == 0) begin
                sec_tick = 1'b1;
                win = 1'b1;
                tick();
                sec_tick = 1'b0;
                win = 1'b0;
                n_total++;
                if ({state, time_left} !== {S_WAIT_Q, 4'd10}) $display("FAIL wait_q_freeze: got state=%0d time_left=%0d, required 2 10", state, time_left); else n_pass++;
            end
            q_valid = 1'b1;
            tick();
            q_valid = 1'b0;
            if (r == 1) begin
                start = 1'b1;
                tick();
                start = 1'b0;
                n_total++;
                if (state !== S_PLAY) $display("FAIL start_in_play: got state=%0d, required 3", state); else n_pass++;
            end
            for (int i = 0; i < 9; i++) begin
                sec_tick = 1'b1;
                tick();
                sec_tick = 1'b0;
                tick();
            end
            n_total++;
            if (time_left !== 4'd1) $display("FAIL countdown_%0d: got time_left=%0d, required 1", r, time_left); else n_pass++;
            model_push(1'b0);
            sec_tick = 1'b1;
            tick();
            sec_tick = 1'b0;
            n_total++;
            if ({state, time_left} !== {S_RESULT, 4'd0}) $display("FAIL expire_%0d: got state=%0d time_left=%0d, required 4 0", r, state, time_left); else n_pass++;
        end
        tick();
        n_total++;
        if ({state, game_over, lives} !== {S_OVER, 1'b1, 2'd0}) $display("FAIL game_over: got state=%0d game_over=%b lives=%0d, required 5 1 0", state, game_over, lives); else n_pass++;
        repeat (3) tick();
        n_total++;
        if ({state, score} !== {S_OVER, 8'd2}) $display("FAIL over_hold: got state=%0d score=%0d, required 5 2", state, score); else n_pass++;
        start = 1'b1;
        tick();
        start = 1'b0;
        n_total++;
        if ({state, game_over} !== {S_IDLE, 1'b0}) $display("FAIL over_to_idle: got state=%0d game_over=%b, required 0 0", state, game_over); else n_pass++;
    endtask

    task automatic test_both_lose();
        new_game();
        play_round(2);
        tick();
        n_total++;
        if ({state, lives} !== {S_REQ, 2'd2}) $display("FAIL both_lose_lives: got state=%0d lives=%0d, required 1 2", state, lives); else n_pass++;
    endtask

    task automatic test_streak();
        for (int i = 0; i < 3; i++) play_round(0);
        tick();
        n_total++;
`ifdef STREAK_BONUS_EN
        if (score !== 8'd4) $display("FAIL streak_score: got %0d, required 4", score); else n_pass++;
`else
        if (score !== 8'd3) $display("FAIL plain_score: got %0d, required 3", score); else n_pass++;
`endif
    endtask

    task automatic test_tick_priority();
        wait_state(S_WAIT_Q, "prio_wait_q");
        q_valid = 1'b1;
        tick();
        q_valid = 1'b0;
        sec_tick = 1'b1;
        tick();
        win = 1'b1;
        model_push(1'b1);
        tick();
        win = 1'b0;
        sec_tick = 1'b0;
        n_total++;
        if ({state, time_left} !== {S_RESULT, 4'd9}) $display("FAIL tick_priority: got state=%0d time_left=%0d, required 4 9", state, time_left); else n_pass++;
    endtask

    task automatic test_saturation();
        while (m_score < 254) play_round(0);
        tick();
        n_total++;
        if (score !== 8'd254) $display("FAIL sat_pre: got score=%0d, required 254", score); else n_pass++;
        for (int i = 0; i < 3; i++) play_round(0);
        tick();
        n_total++;
        if (score !== 8'd255) $display("FAIL sat_hold: got score=%0d, required 255", score); else n_pass++;
    endtask

    task automatic test_reset_mid();
        wait_state(S_WAIT_Q, "rst_wait_q");
        q_valid = 1'b1;
        tick();
        q_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sec_tick = 1'b1;
            tick();
            sec_tick = 1'b0;
            tick();
        end
        n_total++;
        if ({state, time_left} !== {S_PLAY, 4'd5}) $display("FAIL pre_reset: got state=%0d time_left=%0d, required 3 5", state, time_left); else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_total++;
        if ({state, score, lives, time_left, new_q, round_win, round_lose, game_over} !== 21'd0)
            $display("FAIL async_reset: got state=%0d score=%0d lives=%0d time_left=%0d flags=%b, required all 0",
                     state, score, lives, time_left, {new_q, round_win, round_lose, game_over});
        else n_pass++;
        tick();
        rst_n = 1'b1;
        tick();
        n_total++;
        if (state !== S_IDLE) $display("FAIL post_reset_idle: got state=%0d, required 0", state); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic_win();
        test_interlock();
        test_timeout();
        test_both_lose();
        test_streak();
        test_tick_priority();
        test_saturation();
        test_reset_mid();
        n_total++;
        if (exp_q.size() != 0) $display("FAIL scoreboard_drain: got %0d pending results, required 0", exp_q.size()); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
